// File: rtl/vc_pkg.sv
// -----------------------------------------------------------------------------
// vc_pkg
// Shared definitions for the virtual-channel read arbiter: FSM state encoding,
// number of virtual channels and default data/threshold widths.
// -----------------------------------------------------------------------------
package vc_pkg;

  localparam int NUM_VC  = 4;
  localparam int DEF_BW  = 6;
  localparam int DEF_LEN = 4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } vc_state_e;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// the pointer position and wrapping around; the first requester found wins.
//
// Ports:
//   req_i   [NUM_VC]  request vector (1 = source has data)
//   ptr_i   [2]       highest-priority source index
//   gnt_o   [NUM_VC]  one-hot grant (all zero when nothing requests)
//   valid_o           a grant was found
// -----------------------------------------------------------------------------
module rr_pick
  import vc_pkg::*;
(
  input  logic [NUM_VC-1:0] req_i,
  input  logic [1:0]        ptr_i,
  output logic [NUM_VC-1:0] gnt_o,
  output logic              valid_o
);

  logic [1:0] idx;
  logic       found;

  // NOTE: every variable written in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      // 2-bit addition wraps naturally: ptr, ptr+1, ptr+2, ptr+3 (mod 4)
      idx = ptr_i + 2'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
// Four-source round-robin read arbiter. Pops one word per cycle from the
// non-empty VC FIFOs and forwards it, registered, to one downstream FIFO.
// Holds off while the downstream FIFO is almost full. Captures FIFO low/high
// thresholds during INIT and drives them to every FIFO in the stage.
//
// Optional build macro: VC_ARB_WEIGHTED_EN enables weighted round robin
// (per-source burst lengths taken from weights_in).
//
// Ports:
//   clk, reset (sync, active-high)
//   init                 level; holds the block in INIT and captures config
//   umbral_bajo_in/alto_in  thresholds captured in INIT
//   weights_in           per-source weights, WW bits each (weighted build)
//   src_empty, src_data  empty flags and data of VC0..VC3
//   out_almost_full      downstream backpressure
//   src_rd               one-hot pop strobe (combinational)
//   out_wr, out_data     registered write to the downstream FIFO
//   umbral_bajo/alto     registered thresholds
//   state                FSM state (RESET/INIT/IDLE/ACTIVE)
// -----------------------------------------------------------------------------
module vc_arbiter
  import vc_pkg::*;
#(
  parameter int BW  = DEF_BW,
  parameter int LEN = DEF_LEN,
  parameter int WW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [LEN-1:0]       umbral_bajo_in,
  input  logic [LEN-1:0]       umbral_alto_in,
  input  logic [NUM_VC*WW-1:0] weights_in,
  input  logic [NUM_VC-1:0]    src_empty,
  input  logic [NUM_VC*BW-1:0] src_data,
  input  logic                 out_almost_full,
  output logic [NUM_VC-1:0]    src_rd,
  output logic                 out_wr,
  output logic [BW-1:0]        out_data,
  output logic [LEN-1:0]       umbral_bajo,
  output logic [LEN-1:0]       umbral_alto,
  output logic [1:0]           state
);

  vc_state_e       state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            out_wr_q;
  logic [BW-1:0]   out_data_q;
  logic [LEN-1:0]  bajo_q, alto_q;

  logic [NUM_VC-1:0] pick_gnt;
  logic              pick_valid;
  logic              grant_en;
  logic              grant_any;
  logic [1:0]        gnt_idx;
  logic [BW-1:0]     gnt_data;
  logic              capture;

  assign capture = (state_q == ST_INIT) && init;

  // ---------------------------------------------------------------- FSM
  // NOTE: state is stored with non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (init) state_d = ST_INIT;
                 else if (src_empty != 4'hF) state_d = ST_ACTIVE;
      ST_ACTIVE: if (init) state_d = ST_INIT;
                 else if (src_empty == 4'hF) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
  end

  // Grants only in ACTIVE without backpressure; the init cycle and the reset
  // cycle never pop a source.
  always_comb begin
    grant_en = (state_q == ST_ACTIVE) && !init && !out_almost_full && !reset;
    src_rd   = grant_en ? pick_gnt : '0;
  end

  assign state = state_q;

  // ---------------------------------------------------------------- picker
  rr_pick u_pick (
    .req_i   (~src_empty),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  assign grant_any = grant_en && pick_valid;

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (pick_gnt[i]) begin
        gnt_idx  = 2'(i);
        gnt_data = src_data[i*BW +: BW];
      end
    end
  end

  // ---------------------------------------------------------------- pointer
`ifdef VC_ARB_WEIGHTED_EN
  logic [WW-1:0]        cnt_q [NUM_VC];
  logic [WW-1:0]        cnt_d [NUM_VC];
  logic [NUM_VC*WW-1:0] weights_q;
  logic [WW-1:0]        w_raw;
  logic [WW:0]          w_eff;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    w_raw = weights_q[gnt_idx*WW +: WW];
    // A zero weight still gives the source one grant per turn.
    w_eff = (w_raw == '0) ? (WW+1)'(1) : {1'b0, w_raw};
    if (grant_any) begin
      // The pointer source was skipped (it went empty): its burst ends.
      if (gnt_idx != ptr_q) cnt_d[ptr_q] = '0;
      if (({1'b0, cnt_q[gnt_idx]} + (WW+1)'(1)) >= w_eff) begin
        ptr_d          = gnt_idx + 2'd1;
        cnt_d[gnt_idx] = '0;
      end else begin
        ptr_d          = gnt_idx;
        cnt_d[gnt_idx] = cnt_q[gnt_idx] + WW'(1);
      end
    end else if (cnt_q[ptr_q] != '0) begin
      // Burst interrupted by backpressure or an empty source.
      ptr_d        = ptr_q + 2'd1;
      cnt_d[ptr_q] = '0;
    end
  end

  // NOTE: the burst counters are a handful of flops, not a RAM, so they take
  // the synchronous reset like every other register here.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '{default: '0};
      weights_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (capture) weights_q <= weights_in;
    end
  end
`else
  logic unused_weights;
  assign unused_weights = ^weights_in;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = gnt_idx + 2'd1;
  end
`endif

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      bajo_q     <= '0;
      alto_q     <= '0;
    end else begin
      ptr_q    <= ptr_d;
      out_wr_q <= grant_any;
      if (grant_any) out_data_q <= gnt_data;
      if (capture) begin
        bajo_q <= umbral_bajo_in;
        alto_q <= umbral_alto_in;
      end
    end
  end

  assign out_wr      = out_wr_q;
  assign out_data    = out_data_q;
  assign umbral_bajo = bajo_q;
  assign umbral_alto = alto_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_arbiter
// Self-checking bench for vc_arbiter. A behavioural model (integer pointer,
// single burst counter, state number) tracks the expected outputs; inputs are
// driven #1 after the rising edge and outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_vc_arbiter;

  localparam int BW  = 6;
  localparam int LEN = 4;
  localparam int WW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, init;
  logic [LEN-1:0]  ub_in, ua_in;
  logic [4*WW-1:0] w_in;
  logic [3:0]      src_empty;
  logic [4*BW-1:0] src_data;
  logic            afull;
  logic [3:0]      src_rd;
  logic            out_wr;
  logic [BW-1:0]   out_data;
  logic [LEN-1:0]  ub, ua;
  logic [1:0]      state;

  vc_arbiter #(.BW(BW), .LEN(LEN), .WW(WW)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_bajo_in  (ub_in),
    .umbral_alto_in  (ua_in),
    .weights_in      (w_in),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .out_almost_full (afull),
    .src_rd          (src_rd),
    .out_wr          (out_wr),
    .out_data        (out_data),
    .umbral_bajo     (ub),
    .umbral_alto     (ua),
    .state           (state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- model
  int             m_state, m_ptr, m_cnt;
  int             m_w [4];
  logic           m_wr;
  logic [BW-1:0]  m_data;
  logic [LEN-1:0] m_bajo, m_alto;
  int             exp_g;
  logic [3:0]     exp_rd;

  // Expected grant for the current inputs.
  task automatic predict();
    exp_g = -1;
    if (!reset && !init && !afull && m_state == 3) begin
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_ptr + k) % 4;
        if (exp_g < 0 && !src_empty[s]) exp_g = s;
      end
    end
    exp_rd = (exp_g >= 0) ? 4'(1 << exp_g) : 4'h0;
  endtask

  // Apply the rising edge to the model.
  task automatic model_step();
    int w;
    if (reset) begin
      m_state = 0; m_ptr = 0; m_cnt = 0;
      m_wr = 1'b0; m_data = '0; m_bajo = '0; m_alto = '0;
      for (int i = 0; i < 4; i++) m_w[i] = 0;
    end else begin
      m_wr = (exp_g >= 0);
      if (exp_g >= 0) m_data = src_data[exp_g*BW +: BW];
      if (m_state == 1 && init) begin
        m_bajo = ub_in;
        m_alto = ua_in;
        for (int i = 0; i < 4; i++) m_w[i] = int'(w_in[i*WW +: WW]);
      end
`ifdef VC_ARB_WEIGHTED_EN
      if (exp_g >= 0) begin
        if (exp_g != m_ptr) m_cnt = 0;
        m_cnt++;
        w = (m_w[exp_g] == 0) ? 1 : m_w[exp_g];
        if (m_cnt >= w) begin
          m_ptr = (exp_g + 1) % 4;
          m_cnt = 0;
        end else begin
          m_ptr = exp_g;
        end
      end else if (m_cnt > 0) begin
        m_ptr = (m_ptr + 1) % 4;
        m_cnt = 0;
      end
`else
      w = 1;
      if (exp_g >= 0) m_ptr = (exp_g + w) % 4;
`endif
      case (m_state)
        0: m_state = 1;
        1: if (!init) m_state = 2;
        2: if (init) m_state = 1; else if (src_empty != 4'hF) m_state = 3;
        default: if (init) m_state = 1; else if (src_empty == 4'hF) m_state = 2;
      endcase
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic ini, input logic [3:0] emp,
                       input logic af);
    reset = rst; init = ini; src_empty = emp; afull = af;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    ub_in = '0; ua_in = '0; w_in = '0; src_data = '0;
    model_step();
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); predict();
      checks++;
      if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++;
      if (out_wr !== 1'b0 || out_data !== '0) begin
        errors++; $display("FAIL reset_out: out_wr=%b out_data=%h want 0/0", out_wr, out_data);
      end
      checks++;
      if (ub !== '0 || ua !== '0) begin
        errors++; $display("FAIL reset_thresh: bajo=%h alto=%h want 0/0", ub, ua);
      end
      advance();
    end
  endtask

  task automatic test_config();
    ub_in = 4'd1; ua_in = 4'd3;
    w_in  = {2'd2, 2'd0, 2'd1, 2'd3};  // VC3=2 VC2=0 VC1=1 VC0=3
    drive(1'b0, 1'b1, 4'hF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) init = 1'b0;
      if (c == 3) begin ub_in = 4'd7; ua_in = 4'd9; end  // ignored outside INIT
      @(negedge clk); predict();
      checks++;
      if (state !== 2'(m_state)) begin
        errors++; $display("FAIL config_state[%0d]: got %0d want %0d", c, state, m_state);
      end
      advance();
    end
    checks++;
    if (ub !== 4'd1 || ua !== 4'd3 || ub !== m_bajo) begin
      errors++; $display("FAIL config_thresh: bajo=%0d alto=%0d want 1/3", ub, ua);
    end
  endtask

  task automatic run_stream(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk); predict();
      checks++;
      if (src_rd !== exp_rd) begin
        errors++; $display("FAIL %s_rd[%0d]: got %h want %h", name, c, src_rd, exp_rd);
      end
      checks++;
      if (out_wr !== m_wr || (m_wr && out_data !== m_data)) begin
        errors++;
        $display("FAIL %s_out[%0d]: wr=%b data=%h want wr=%b data=%h",
                 name, c, out_wr, out_data, m_wr, m_data);
      end
      checks++;
      if (state !== 2'(m_state)) begin
        errors++; $display("FAIL %s_state[%0d]: got %0d want %0d", name, c, state, m_state);
      end
      advance();
    end
  endtask

  task automatic test_all_busy();
    src_data = {6'h04, 6'h03, 6'h02, 6'h01};
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    run_stream("busy", 12);
  endtask

  task automatic test_sparse();
    drive(1'b0, 1'b0, 4'b0101, 1'b0);
    run_stream("sparse", 6);
    src_empty = 4'b1101;
    run_stream("sparse_vc1", 5);
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    run_stream("bp_pre", 3);
    afull = 1'b1;
    run_stream("bp_hold", 3);
    afull = 1'b0;
    run_stream("bp_resume", 5);
  endtask

  task automatic test_empty();
    drive(1'b0, 1'b0, 4'hF, 1'b0);
    run_stream("empty", 3);
    src_empty = 4'b1011;
    run_stream("push_vc2", 4);
  endtask

  task automatic test_weighted_reset();
    // Reload the weights, then stream with every source busy.
    w_in = {2'd2, 2'd0, 2'd1, 2'd3};
    drive(1'b0, 1'b1, 4'h0, 1'b0);
    run_stream("reinit", 2);
    init = 1'b0;
    run_stream("weighted", 16);
    // Reset in the middle of a burst, then restart.
    reset = 1'b1;
    @(negedge clk); predict(); advance();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_wr !== 1'b0) begin errors++; $display("FAIL midreset_wr: got %b want 0", out_wr); end
    predict(); advance();
    run_stream("restart", 8);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 63) == 0);
      init      = ($urandom_range(0, 31) == 0);
      afull     = ($urandom_range(0, 3) == 0);
      src_empty = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 15) == 0) src_empty = 4'hF;
      src_data  = 24'($urandom);
      ub_in     = 4'($urandom);
      ua_in     = 4'($urandom);
      w_in      = 8'($urandom);
      @(negedge clk); predict();
      if (!reset) begin
        checks++;
        if (src_rd !== exp_rd) begin
          errors++; $display("FAIL rand_rd[%0d]: got %h want %h", c, src_rd, exp_rd);
        end
      end
      checks++;
      if (out_wr !== m_wr || out_data !== m_data || state !== 2'(m_state) ||
          ub !== m_bajo || ua !== m_alto) begin
        errors++;
        $display("FAIL rand_regs[%0d]: wr=%b data=%h st=%0d lo=%h hi=%h want %b %h %0d %h %h",
                 c, out_wr, out_data, state, ub, ua, m_wr, m_data, m_state, m_bajo, m_alto);
      end
      advance();
    end
    reset = 1'b0; init = 1'b0; afull = 1'b0;
  endtask

  initial begin
    test_reset();
    test_config();
    test_all_busy();
    test_sparse();
    test_backpressure();
    test_empty();
    test_weighted_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

Four-source round-robin read arbiter for the virtual-channel FIFO stage. It pops one word per cycle from the non-empty source FIFOs (VC0..VC3) and forwards each word, registered, into a single downstream FIFO. It holds off while the downstream FIFO reports almost-full. It also owns FIFO threshold configuration: it captures low/high thresholds during an init phase and drives them to every FIFO in the stage.

## Interface
Parameters:
- BW, 6: data width of every FIFO word.
- LEN, 4: threshold width; matches the FIFO threshold ports.
- WW, 2: per-source weight width; used only with the weighted build.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  level; while high, the block is in INIT and captures configuration.
- umbral_bajo_in  in  LEN  low threshold, captured in INIT.
- umbral_alto_in  in  LEN  high threshold, captured in INIT.
- weights_in  in  4*WW  per-source weights, captured in INIT; weighted build only. Source i uses bits [i*WW +: WW].
- src_empty  in  4  fifo_empty of VC0..VC3.
- src_data  in  4*BW  fifo_data_out of VC0..VC3; source i uses [i*BW +: BW].
- out_almost_full  in  1  almost-full flag of the downstream FIFO.
- src_rd  out  4  one-hot pop strobe to the source FIFOs; combinational.
- out_wr  out  1  write strobe to the downstream FIFO; registered.
- out_data  out  BW  write data to the downstream FIFO; registered.
- umbral_bajo  out  LEN  low threshold driven to all FIFOs; registered.
- umbral_alto  out  LEN  high threshold driven to all FIFOs; registered.
- state  out  2  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.

## Operation
- FSM transitions:
  - RESET: always goes to INIT on the next cycle.
  - INIT: goes to IDLE when init is low.
  - IDLE: goes to ACTIVE when src_empty != 4'hF.
  - ACTIVE: goes to IDLE when src_empty == 4'hF.
  - From IDLE or ACTIVE, init high goes to INIT. A grant is not issued in the cycle init is seen high.
- INIT captures umbral_bajo_in, umbral_alto_in and weights_in every cycle while init is high; the last captured values are kept.
- Grants are issued only in ACTIVE and only when out_almost_full is 0. Otherwise src_rd = 0.
- Round robin:
  - A 2-bit pointer ptr names the highest-priority source.
  - Sources are searched in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first source with src_empty[i]=0 is granted, and src_rd[i]=1 in the same cycle.
  - After a grant to source g, ptr becomes g+1 (mod 4); 3 wraps to 0.
  - With no grant, ptr is unchanged.
- Forwarding: on the edge that closes a grant cycle, out_data <= src_data[g] and out_wr <= 1. In any cycle without a grant, out_wr <= 0 and out_data holds its value.
- src_rd is never asserted for an empty source; at most one bit of src_rd is set.

## Timing
- Reset values: state=RESET, ptr=0, out_wr=0, out_data=0, umbral_bajo=0, umbral_alto=0, weight counters=0.
  - src_rd=0, because state is not ACTIVE.
- Reset dominates everything. Reset asserted mid-operation drops out_wr on the next edge; a grant in the reset cycle is discarded.
- Latency:
  - src_rd to out_wr: 1 cycle.
  - Fastest path from reset release to first grant: RESET, INIT, IDLE, ACTIVE. The first grant is 3 cycles after reset deassertion, with init low and a source non-empty throughout.
- Throughput: 1 word per cycle.
- Backpressure is sampled combinationally. Because out_wr lags src_rd by one cycle, one word can still land after almost-full rises. Downstream umbral_alto must therefore be ≤ LEN-1.
- A threshold change is visible on umbral_bajo/umbral_alto 1 cycle after capture.

## Configuration
- VC_ARB_WEIGHTED_EN defined (weighted round robin):
  - Each source has a WW-bit burst counter.
  - A granted source keeps priority (ptr stays at g) until it has received weights_in[g] consecutive grants. A weight of 0 counts as 1.
  - ptr then advances to g+1 and the counter clears.
  - Losing eligibility because the source went empty, or because of backpressure, also advances ptr to g+1 and clears the counter.
- VC_ARB_WEIGHTED_EN undefined: plain round robin as described above. weights_in is ignored and no counters are built.

## Structure
- Package vc_pkg:
  - state encoding constants ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE;
  - NUM_VC=4;
  - the default BW and LEN.
- One sub-module, rr_pick: 4-bit request vector plus 2-bit pointer in, one-hot grant plus valid out; purely combinational. The arbiter FSM, registers and weight logic stay in vc_arbiter.

## Test plan
- Reset then config: release reset with init high for 2 cycles and umbral_bajo_in=1, umbral_alto_in=3.
  - state goes 0→1; after init falls, state=2.
  - umbral_bajo=1 and umbral_alto=3 are held.
- All sources busy: src_empty=4'h0 with distinct data 0x01..0x04 per VC.
  - src_rd sequence is 1,2,4,8,1,…
  - out_data is 0x01,0x02,0x03,0x04, each one cycle after its src_rd.
- Sparse requests: only VC1 and VC3 non-empty → alternating grants 2,8,2,8.
  - When VC3 empties, VC1 is granted every cycle.
- Backpressure: raise out_almost_full for 3 cycles mid-stream.
  - src_rd=0 in those cycles; out_wr=0 from the following cycle.
  - Resumption starts at the saved ptr.
- Empty transition: all sources go empty → state=2 next cycle and out_wr=0.
  - A single push to VC2 → state=3, then src_rd=4.
- Weighted build (VC_ARB_WEIGHTED_EN) with weights {VC0=3, VC1=1, VC2=0, VC3=2} and all sources busy:
  - grant pattern per round is VC0 ×3, VC1 ×1, VC2 ×1, VC3 ×2, repeating.
  - Reset mid-burst → out_wr=0 next cycle and ptr=0.
